laser_drop_word_queue: RTL and testbench



---
 rtl/laser_drop_word_queue_pkg.sv | 10 +
 rtl/laser_drop_word_queue.sv | 112 +++++++++++
 tb/tb_laser_drop_word_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/laser_drop_word_queue_pkg.sv
// Types and defaults shared by the LaserDrop transmit and receive queues.
package laser_drop_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;

    localparam int    LD_QUEUE_DEPTH = 64;
    localparam byte_t LD_PAD_BYTE    = 8'h00;

endpackage

// File: rtl/laser_drop_word_queue.sv
// LaserDrop receive queue: bytes in from the laser path, 16-bit low-byte-first
// words out to the host. A flush pads an odd trailing byte so it can drain.
module laser_drop_word_queue
    import laser_drop_pkg::*;
#(
    parameter int    DEPTH = LD_QUEUE_DEPTH,
    parameter byte_t PAD   = LD_PAD_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  D,
    input  logic        load,
    input  logic        read,
    input  logic        flush,
    output logic [15:0] Q,
    output logic [7:0]  size,
    output logic        empty,
    output logic        full,
    output logic        dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_TWO  = AW'(2);
    localparam logic [SW-1:0] CNT_ZERO = SW'(0);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);
    localparam logic [SW-1:0] CNT_TWO  = SW'(2);
    localparam logic [SW-1:0] CNT_FULL = SW'(DEPTH);

    logic [DEPTH-1:0][7:0] mem_q, mem_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [AW-1:0]         wr_q, wr_d;
    logic [SW-1:0]         size_q, size_d;
    logic                  dropped_q, dropped_d;

    logic full_s;
    logic empty_s;
    logic load_ok;
    logic read_ok;
    logic flush_ok;
    logic flush_rej;
    logic wr_en;
    byte_t wr_data;

    // Acceptance is judged purely on pre-edge state, independently per request.
    assign full_s    = (size_q == CNT_FULL);
    assign empty_s   = (size_q < CNT_TWO);
    assign load_ok   = load & ~full_s;
    assign read_ok   = read & ~empty_s;
    assign flush_ok  = flush & ~load & size_q[0];
    assign flush_rej = flush & load;
    assign wr_en     = load_ok | flush_ok;
    assign wr_data   = load_ok ? D : PAD;

    // read pointer is always even, so OR-ing in bit 0 addresses the high byte.
    assign Q       = {mem_q[rd_q | PTR_ONE], mem_q[rd_q]};
    assign size    = 8'(size_q);
    assign empty   = empty_s;
    assign full    = full_s;
    assign dropped = dropped_q;

    // Next-state for storage, pointers, fill count and the drop pulse.
    always_comb begin
        mem_d     = mem_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        size_d    = size_q;
        dropped_d = 1'b0;
        if (clear) begin
            mem_d  = '0;
            rd_d   = '0;
            wr_d   = '0;
            size_d = CNT_ZERO;
        end else begin
            if (wr_en) begin
                mem_d[wr_q] = wr_data;
                wr_d        = wr_q + PTR_ONE;
            end else begin
                wr_d = wr_q;
            end
            if (read_ok) begin
                rd_d = rd_q + PTR_TWO;
            end else begin
                rd_d = rd_q;
            end
            size_d    = size_q + (wr_en ? CNT_ONE : CNT_ZERO)
                               - (read_ok ? CNT_TWO : CNT_ZERO);
            dropped_d = (load & full_s) | flush_rej;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            size_q    <= CNT_ZERO;
            dropped_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            dropped_q <= dropped_d;
        end
    end

endmodule

// File: tb/tb_laser_drop_word_queue.sv
// Bench for laser_drop_word_queue: directed cases plus random traffic against
// a byte-queue reference model.
module tb_laser_drop_word_queue;
    import laser_drop_pkg::*;

    localparam int         DEPTH = 64;
    localparam logic [7:0] PAD   = 8'h00;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [7:0]  D;
    logic        load;
    logic        read;
    logic        flush;
    logic [15:0] Q;
    logic [7:0]  size;
    logic        empty;
    logic        full;
    logic        dropped;

    int    err_cnt = 0;
    int    chk_cnt = 0;
    byte_t mq[$];
    logic  exp_drop;

    always #5 clock = ~clock;

    laser_drop_word_queue #(.DEPTH(DEPTH), .PAD(PAD)) dut (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .D       (D),
        .load    (load),
        .read    (read),
        .flush   (flush),
        .Q       (Q),
        .size    (size),
        .empty   (empty),
        .full    (full),
        .dropped (dropped)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        check_eq({where, ":size"},    32'(size),    32'(mq.size()));
        check_eq({where, ":empty"},   32'(empty),   32'(mq.size() < 2));
        check_eq({where, ":full"},    32'(full),    32'(mq.size() == DEPTH));
        check_eq({where, ":dropped"}, 32'(dropped), 32'(exp_drop));
        if (mq.size() >= 2) begin
            check_eq({where, ":Q"}, 32'(Q), 32'({mq[1], mq[0]}));
        end
    endtask

    task automatic step(input logic ld, input logic [7:0] d, input logic rd,
                        input logic fl, input logic cl, input string where);
        int n;
        bit acc_load;
        bit acc_read;
        bit acc_flush;
        load  = ld;
        D     = d;
        read  = rd;
        flush = fl;
        clear = cl;
        n         = mq.size();
        acc_load  = ld && (n < DEPTH);
        acc_read  = rd && (n >= 2);
        acc_flush = fl && !ld && (n % 2 == 1);
        @(posedge clock);
        #1;
        if (cl) begin
            mq.delete();
            exp_drop = 1'b0;
        end else begin
            if (acc_read) begin
                void'(mq.pop_front());
                void'(mq.pop_front());
            end
            if (acc_load) mq.push_back(d);
            else if (acc_flush) mq.push_back(PAD);
            exp_drop = (ld && !acc_load) || (fl && ld);
        end
        load  = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
        clear = 1'b0;
        check_outputs(where);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        load  = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
        D     = 8'h00;
        exp_drop = 1'b0;
        #2;
        check_outputs("reset");
        check_eq("reset:Q", 32'(Q), 32'h0000);
        #20;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Pairing, low byte first
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "pair1");
        check_eq("pair1:empty_const", 32'(empty), 32'h1);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, "pair2");
        check_eq("pair2:Q_const", 32'(Q), 32'h3CA5);
        check_eq("pair2:size_const", 32'(size), 32'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pair_rd");
        check_eq("pair_rd:size_const", 32'(size), 32'd0);

        // Odd trailing byte flush
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "odd1");
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, "odd2");
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, "odd3");
        check_eq("odd3:Q_const", 32'(Q), 32'h2211);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "odd_rd");
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush1");
        check_eq("flush1:Q_const", 32'(Q), 32'h0033);
        check_eq("flush1:size_const", 32'(size), 32'd2);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush_even");
        check_eq("flush_even:size_const", 32'(size), 32'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "flush_rd");

        // Fill to full, then a rejected load alongside an accepted read
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
        check_eq("fill:full_const", 32'(full), 32'h1);
        check_eq("fill:size_const", 32'(size), 32'd64);
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "full_drop");
        check_eq("full_drop:dropped_const", 32'(dropped), 32'h1);
        check_eq("full_drop:size_const", 32'(size), 32'd62);
        check_eq("full_drop:Q_const", 32'(Q), 32'h0302);

        // Drain and wrap
        for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        step(1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, "wrap1");
        step(1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, "wrap2");
        check_eq("wrap2:Q_const", 32'(Q), 32'hADDE);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wrap_rd");
        check_eq("wrap_rd:size_const", 32'(size), 32'd0);

        // Read at size 1 is rejected even when a load completes the pair
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "s1_load");
        step(1'b1, 8'h88, 1'b1, 1'b0, 1'b0, "s1_ldrd");
        check_eq("s1_ldrd:size_const", 32'(size), 32'd2);
        check_eq("s1_ldrd:Q_const", 32'(Q), 32'h8877);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "s1_rd");

        // Flush together with load: flush dropped
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, "fl_ld");
        check_eq("fl_ld:dropped_const", 32'(dropped), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "fl_ld_idle");
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "fl_pad");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "fl_rd");

        // Clear beats load
        step(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, "clr_pre");
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, "clr_ld");
        check_eq("clr_ld:size_const", 32'(size), 32'd0);
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, "clr_post1");
        step(1'b1, 8'h56, 1'b0, 1'b0, 1'b0, "clr_post2");
        check_eq("clr_post2:Q_const", 32'(Q), 32'h5634);

        // Random traffic with alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int  pl;
            int  pr;
            logic ld;
            logic rd;
            logic fl;
            logic cl;
            pl = ((i / 400) % 2 == 0) ? 70 : 30;
            pr = ((i / 400) % 2 == 0) ? 25 : 65;
            ld = ($urandom_range(99) < pl);
            rd = ($urandom_range(99) < pr);
            fl = ($urandom_range(99) < 12);
            cl = ($urandom_range(999) < 4);
            step(ld, 8'($urandom), rd, fl, cl, "rand");
        end

        // Asynchronous reset mid-cycle
        step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, "ar1");
        step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, "ar2");
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, "ar3");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        exp_drop = 1'b0;
        check_outputs("async_rst");
        check_eq("async_rst:Q", 32'(Q), 32'h0000);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, "post_rst1");
        step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0, "post_rst2");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
